// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM stage: bubble constants, opcode width, skid FSM encoding.
// The skid state encoding equals the number of held entries, so it doubles as the occupancy count.
package ex_mem_pipe_pkg;

  localparam int   OP_WIDTH     = 8;
  localparam int   ZERO_WORD    = 0;
  localparam int   NOP_REG_ADDR = 0;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-slot skid buffer: main slot drives the output, skid slot absorbs one bundle
// while the consumer stalls. in_ready comes from registered state only.
module ex_mem_skid
  import ex_mem_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             drain;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Held entries and any same-cycle accept are squashed.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage with valid/ready back-pressure, two-entry skid buffer and flush.
// Define EX_MEM_HILO_EN to carry the HI/LO write fields through the stage.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = OP_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [OP_W-1:0]   ex_aluop,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_sdata,
`ifdef EX_MEM_HILO_EN
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
`endif
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [REG_AW-1:0] mem_rw,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [OP_W-1:0]   mem_aluop,
  output logic [ADDR_W-1:0] mem_mem_addr,
  output logic [DATA_W-1:0] mem_sdata,
  output logic [1:0]        occ
);

  localparam int BASE_W = 2 * ADDR_W + REG_AW + 1 + 2 * DATA_W + OP_W;
`ifdef EX_MEM_HILO_EN
  localparam int BUNDLE_W = BASE_W + 1 + 2 * DATA_W;
`else
  localparam int BUNDLE_W = BASE_W;
`endif

  logic [BUNDLE_W-1:0] in_bundle;
  logic [BUNDLE_W-1:0] out_bundle;

  logic [ADDR_W-1:0] held_pc;
  logic [REG_AW-1:0] held_rw;
  logic              held_wreg;
  logic [DATA_W-1:0] held_wdata;
  logic [OP_W-1:0]   held_aluop;
  logic [ADDR_W-1:0] held_mem_addr;
  logic [DATA_W-1:0] held_sdata;

`ifdef EX_MEM_HILO_EN
  logic              held_whilo;
  logic [DATA_W-1:0] held_hi;
  logic [DATA_W-1:0] held_lo;

  assign in_bundle = {pc_i, ex_rw, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_sdata,
                      ex_whilo, ex_hi, ex_lo};
  assign {held_pc, held_rw, held_wreg, held_wdata, held_aluop, held_mem_addr, held_sdata,
          held_whilo, held_hi, held_lo} = out_bundle;

  assign mem_whilo = mem_valid ? held_whilo : DISABLE;
  assign mem_hi    = mem_valid ? held_hi    : DATA_W'(ZERO_WORD);
  assign mem_lo    = mem_valid ? held_lo    : DATA_W'(ZERO_WORD);
`else
  assign in_bundle = {pc_i, ex_rw, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_sdata};
  assign {held_pc, held_rw, held_wreg, held_wdata, held_aluop, held_mem_addr, held_sdata} =
         out_bundle;
`endif

  ex_mem_skid #(
    .WIDTH(BUNDLE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (ex_valid),
    .in_ready (ex_ready),
    .in_data  (in_bundle),
    .out_valid(mem_valid),
    .out_ready(mem_ready),
    .out_data (out_bundle),
    .occ      (occ)
  );

  // Outputs read as a clean bubble whenever nothing is held.
  assign pc_o         = mem_valid ? held_pc       : ADDR_W'(ZERO_WORD);
  assign mem_rw       = mem_valid ? held_rw       : REG_AW'(NOP_REG_ADDR);
  assign mem_wreg     = mem_valid ? held_wreg     : DISABLE;
  assign mem_wdata    = mem_valid ? held_wdata    : DATA_W'(ZERO_WORD);
  assign mem_aluop    = mem_valid ? held_aluop    : OP_W'(ZERO_WORD);
  assign mem_mem_addr = mem_valid ? held_mem_addr : ADDR_W'(ZERO_WORD);
  assign mem_sdata    = mem_valid ? held_sdata    : DATA_W'(ZERO_WORD);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe; HI/LO checks run when EX_MEM_HILO_EN is defined.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] pc_i;
  logic [4:0]  ex_rw;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_sdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] pc_o;
  logic [4:0]  mem_rw;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_sdata;
  logic [1:0]  occ;
`ifdef EX_MEM_HILO_EN
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .pc_i        (pc_i),
    .ex_rw       (ex_rw),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_aluop    (ex_aluop),
    .ex_mem_addr (ex_mem_addr),
    .ex_sdata    (ex_sdata),
`ifdef EX_MEM_HILO_EN
    .ex_whilo    (ex_whilo),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
`endif
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .pc_o        (pc_o),
    .mem_rw      (mem_rw),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_aluop   (mem_aluop),
    .mem_mem_addr(mem_mem_addr),
    .mem_sdata   (mem_sdata),
    .occ         (occ)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Secondary fields follow from pc/wdata: aluop = pc[7:0], addr = pc + 0x1000, sdata = ~wdata.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rw,
                       input logic wreg, input logic [31:0] wd);
    ex_valid    = v;
    pc_i        = pc;
    ex_rw       = rw;
    ex_wreg     = wreg;
    ex_wdata    = wd;
    ex_aluop    = pc[7:0];
    ex_mem_addr = pc + 32'h1000;
    ex_sdata    = ~wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b1;
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
`endif
    drive(1'b1, 32'h0000_0040, 5'd9, 1'b1, 32'h1234_5678);
    step(); step();
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    n_checks++; if (mem_wreg !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wreg: got %b want 0", mem_wreg); end
    n_checks++; if (pc_o !== 32'h0 || mem_wdata !== 32'h0 || mem_rw !== 5'd0)
      begin n_fail++; $display("FAIL reset_bubble: got pc=%h wdata=%h rw=%0d want 0/0/0", pc_o, mem_wdata, mem_rw); end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    $display("reset: occ=%0d mem_valid=%b ex_ready=%b", occ, mem_valid, ex_ready);
  endtask

  task automatic test_single();
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_0100, 5'd5, 1'b1, 32'hDEAD_BEEF);
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL single_occ0: got %0d want 0", occ); end
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL single_occ1: got %0d want 1", occ); end
    n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", mem_valid); end
    n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h want 00000100", pc_o); end
    n_checks++; if (mem_rw !== 5'd5 || mem_wreg !== 1'b1)
      begin n_fail++; $display("FAIL single_rw: got rw=%0d wreg=%b want 5/1", mem_rw, mem_wreg); end
    n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", mem_wdata); end
    n_checks++; if (mem_aluop !== 8'h00 || mem_mem_addr !== 32'h1100 || mem_sdata !== 32'h2152_4110)
      begin n_fail++; $display("FAIL single_memop: got op=%h addr=%h sdata=%h want 00/00001100/21524110", mem_aluop, mem_mem_addr, mem_sdata); end
    step();
    n_checks++; if (mem_valid !== 1'b0 || occ !== 2'd0)
      begin n_fail++; $display("FAIL single_drain: got valid=%b occ=%0d want 0/0", mem_valid, occ); end
    n_checks++; if (mem_wdata !== 32'h0 || mem_wreg !== 1'b0)
      begin n_fail++; $display("FAIL single_bubble: got wdata=%h wreg=%b want 0/0", mem_wdata, mem_wreg); end
    $display("single: pc 0x100 passed through one-cycle stage");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'h200 + 32'(4 * i);
      drive(1'b1, exp_pc, 5'(i + 1), i[0], 32'hA000_0000 + 32'(i));
      n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ex_ready); end
      step();
      n_checks++; if (mem_valid !== 1'b1 || pc_o !== exp_pc)
        begin n_fail++; $display("FAIL b2b_pc[%0d]: got valid=%b pc=%h want 1/%h", i, mem_valid, pc_o, exp_pc); end
      n_checks++; if (mem_wdata !== 32'hA000_0000 + 32'(i) || mem_rw !== 5'(i + 1) || mem_wreg !== i[0])
        begin n_fail++; $display("FAIL b2b_data[%0d]: got wdata=%h rw=%0d wreg=%b", i, mem_wdata, mem_rw, mem_wreg); end
      $display("b2b: bundle %0d pc=%h occ=%0d", i, pc_o, occ);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    step();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got valid=%b want 0", mem_valid); end
  endtask

  task automatic test_stall();
    mem_ready = 1'b0;
    drive(1'b1, 32'h300, 5'd1, 1'b1, 32'hAAAA_0001);
    step();
    n_checks++; if (occ !== 2'd1 || pc_o !== 32'h300)
      begin n_fail++; $display("FAIL stall_a: got occ=%0d pc=%h want 1/300", occ, pc_o); end
    drive(1'b1, 32'h304, 5'd2, 1'b1, 32'hBBBB_0002);
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_one: got %b want 1", ex_ready); end
    step();
    n_checks++; if (occ !== 2'd2 || ex_ready !== 1'b0)
      begin n_fail++; $display("FAIL stall_full: got occ=%0d ready=%b want 2/0", occ, ex_ready); end
    drive(1'b1, 32'h308, 5'd3, 1'b1, 32'hCCCC_0003);
    step();
    n_checks++; if (occ !== 2'd2 || pc_o !== 32'h300)
      begin n_fail++; $display("FAIL stall_hold: got occ=%0d pc=%h want 2/300", occ, pc_o); end
    mem_ready = 1'b1;
    step();
    n_checks++; if (pc_o !== 32'h304 || mem_wdata !== 32'hBBBB_0002 || occ !== 2'd1 || ex_ready !== 1'b1)
      begin n_fail++; $display("FAIL stall_b: got pc=%h wdata=%h occ=%0d ready=%b want 304/bbbb0002/1/1", pc_o, mem_wdata, occ, ex_ready); end
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    n_checks++; if (pc_o !== 32'h308 || mem_wdata !== 32'hCCCC_0003 || occ !== 2'd1)
      begin n_fail++; $display("FAIL stall_c: got pc=%h wdata=%h occ=%0d want 308/cccc0003/1", pc_o, mem_wdata, occ); end
    step();
    n_checks++; if (mem_valid !== 1'b0 || occ !== 2'd0)
      begin n_fail++; $display("FAIL stall_end: got valid=%b occ=%0d want 0/0", mem_valid, occ); end
    $display("stall: A B C drained in order");
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive(1'b1, 32'h400, 5'd4, 1'b1, 32'h0000_0A0A);
    step();
    drive(1'b1, 32'h404, 5'd4, 1'b1, 32'h0000_0B0B);
    step();
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_fill: got occ=%0d want 2", occ); end
    flush = 1'b1;
    drive(1'b1, 32'h4F0, 5'd7, 1'b1, 32'h0000_0D0D);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    n_checks++; if (occ !== 2'd0 || mem_valid !== 1'b0 || mem_wreg !== 1'b0 || ex_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_full: got occ=%0d valid=%b wreg=%b ready=%b want 0/0/0/1", occ, mem_valid, mem_wreg, ex_ready); end
    step();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak: got valid=%b pc=%h want 0", mem_valid, pc_o); end
    // flush in ONE with a simultaneous accept and drain
    mem_ready = 1'b1;
    drive(1'b1, 32'h500, 5'd8, 1'b1, 32'h0000_0E0E);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h504, 5'd8, 1'b1, 32'h0000_0F0F);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    n_checks++; if (occ !== 2'd0 || mem_valid !== 1'b0)
      begin n_fail++; $display("FAIL flush_one: got occ=%0d valid=%b pc=%h want 0/0", occ, mem_valid, pc_o); end
    $display("flush: stage emptied, new bundle discarded");
  endtask

  task automatic test_rst_full();
    mem_ready = 1'b0;
    drive(1'b1, 32'h600, 5'd10, 1'b1, 32'h6666_0000);
    step();
    drive(1'b1, 32'h604, 5'd11, 1'b1, 32'h6666_0001);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (occ !== 2'd0 || mem_valid !== 1'b0 || ex_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstfull_state: got occ=%0d valid=%b ready=%b want 0/0/1", occ, mem_valid, ex_ready); end
    n_checks++; if (pc_o !== 32'h0 || mem_wreg !== 1'b0 || mem_sdata !== 32'h0 || mem_mem_addr !== 32'h0)
      begin n_fail++; $display("FAIL rstfull_bubble: got pc=%h wreg=%b sdata=%h addr=%h want 0", pc_o, mem_wreg, mem_sdata, mem_mem_addr); end
    mem_ready = 1'b1;
    drive(1'b1, 32'h700, 5'd12, 1'b1, 32'h7777_7777);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    n_checks++; if (mem_valid !== 1'b1 || pc_o !== 32'h700 || mem_wdata !== 32'h7777_7777)
      begin n_fail++; $display("FAIL rstfull_next: got valid=%b pc=%h wdata=%h want 1/700/77777777", mem_valid, pc_o, mem_wdata); end
    step();
    $display("rst_full: held bundles dropped, next bundle pc=0x700 passed");
  endtask

`ifdef EX_MEM_HILO_EN
  task automatic test_hilo();
    mem_ready = 1'b1;
    drive(1'b1, 32'h800, 5'd0, 1'b0, 32'h0);
    ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
    n_checks++; if (mem_whilo !== 1'b1 || mem_hi !== 32'h1 || mem_lo !== 32'h2)
      begin n_fail++; $display("FAIL hilo: got whilo=%b hi=%h lo=%h want 1/1/2", mem_whilo, mem_hi, mem_lo); end
    step();
    n_checks++; if (mem_whilo !== 1'b0) begin n_fail++; $display("FAIL hilo_bubble: got %b want 0", mem_whilo); end
    $display("hilo: hi/lo carried through");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_rst_full();
`ifdef EX_MEM_HILO_EN
    test_hilo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline stage with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It sits between the execute and memory stages and carries the full EX result bundle (PC, write-back target, ALU result, memory-op fields, optional HI/LO). It replaces the plain always-advancing stage register so that downstream stalls apply back-pressure without a combinational ready path, and so that exceptions and branches can squash in-flight results.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, register and data width
- REG_AW, 5, register-file address width
- OP_W, 8, ALU/memory opcode width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  squash all held entries
- ex_valid  in  1  EX bundle valid
- ex_ready  out  1  stage can accept; registered
- pc_i  in  ADDR_W  instruction PC
- ex_rw  in  REG_AW  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  ALU result
- ex_aluop  in  OP_W  opcode for MEM
- ex_mem_addr  in  ADDR_W  load/store address
- ex_sdata  in  DATA_W  store data
- ex_whilo, ex_hi, ex_lo  in  1/DATA_W/DATA_W  HI/LO write (HILO_EN only)
- mem_valid  out  1  output bundle valid
- mem_ready  in  1  MEM accepts
- pc_o, mem_rw, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_sdata  out  as inputs  registered bundle
- mem_whilo, mem_hi, mem_lo  out  1/DATA_W/DATA_W  (HILO_EN only)
- occ  out  2  entries held (0..2)

## Operation
- Two entry slots: main (drives outputs) and skid. FSM states EMPTY (occ=0), ONE (main valid), FULL (main and skid valid).
- Accept = ex_valid & ex_ready; drain = mem_valid & mem_ready.
- EMPTY: accept -> load main, go to ONE.
- ONE: accept & drain -> main <= new, stay ONE; accept only -> skid <= new, go to FULL; drain only -> EMPTY.
- FULL: drain -> main <= skid, go to ONE; otherwise hold. ex_ready=0, so no accept in FULL.
- ex_ready = (state != FULL), taken from the registered state. There is no combinational path from mem_ready to ex_ready.
- Order is strict FIFO; no bundle is dropped or duplicated.
- When mem_valid=0, every bundle output is driven to its bubble value: ZeroWord, NOPRegAddr, and Disable for the enables.
- flush: on the next edge the state goes to EMPTY. Any same-cycle accept is discarded. flush has priority over every transition except rst.
- mem_wreg and mem_whilo are asserted only when mem_valid=1.

## Timing
- Reset (rst=1 at an edge): state EMPTY, occ=0, mem_valid=0, ex_ready=1 after the edge, all bundle outputs at bubble values.
- Latency: a bundle accepted at edge N appears on the outputs after edge N (mem_valid=1 in cycle N+1).
- Throughput: 1 bundle/cycle while mem_ready=1.
- The stage absorbs one extra bundle after mem_ready falls. ex_ready falls one cycle later.
- rst or flush mid-stall: held bundles are lost, with no partial output.
- flush together with drain: the drain is still counted by MEM, which sampled it. The stage still ends EMPTY.

## Configuration
- HIOLO_EN is not used; the macro is EX_MEM_HILO_EN.
- Defined: the HI/LO fields (ex_whilo/ex_hi/ex_lo and the mem_* counterparts) exist and are carried through both slots.
- Undefined: those ports and registers are absent. All other behaviour is identical.

## Structure
- Bubble constants (ZeroWord, NOPRegAddr, Enable/Disable), the FSM state encodings and the opcode width belong in the shared defines.v header.
- One sub-module: ex_mem_skid. It is a generic WIDTH-parametrised two-slot skid buffer holding the FSM.
- ex_mem_pipe packs the bundle into a vector, instantiates ex_mem_skid, unpacks the result and applies output bubbling.

## Test plan
- Reset hold then release, mem_ready=1, one bundle (pc 0x100, rw 5, wreg 1, wdata 0xDEADBEEF) -> outputs match one cycle later; mem_valid for 1 cycle; occ 0->1->0.
- Back-to-back stream of 8 bundles, mem_ready=1 -> 8 consecutive valid cycles, in order, ex_ready constantly 1.
- mem_ready=0 while streaming -> occ reaches 2, ex_ready=0 the following cycle; release -> bundles A, B, C exit in order with no loss.
- FULL plus flush with ex_valid=1 -> next cycle occ=0, mem_valid=0, mem_wreg=0, ex_ready=1; the new bundle is not seen.
- rst asserted while FULL -> all outputs at bubble values after the edge; next accepted bundle passes normally.
- EX_MEM_HILO_EN defined, whilo=1, hi 0x1, lo 0x2 -> mem_hi/mem_lo = 0x1/0x2; undefined build -> compiles without those ports.
